// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - shared FSM encoding and ROM entry layout for the I2C config sequencer
package i2c_cfg_pkg;

  localparam int ENTRY_W  = 15;
  localparam int ADDR_MSB = 14;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_GAP,
    S_DONE,
    S_FAIL
  } state_t;

endpackage

// File: rtl/i2c_config_rom.sv
// rtl/i2c_config_rom.sv - synchronous-read table of {slave address, data byte} write entries
module i2c_config_rom
  import i2c_cfg_pkg::*;
(
  input  logic               i_Clk,
  input  logic [7:0]         i_Addr,
  output logic [ENTRY_W-1:0] o_Data
);

  logic [ENTRY_W-1:0] r_Data;

  always_ff @(posedge i_Clk) begin
    case (i_Addr)
      8'd0:    r_Data <= {7'h51, 8'hAC};
      8'd1:    r_Data <= {7'h51, 8'h01};
      8'd2:    r_Data <= {7'h20, 8'hFF};
      8'd3:    r_Data <= {7'h1A, 8'h10};
      8'd4:    r_Data <= {7'h1A, 8'h22};
      8'd5:    r_Data <= {7'h3C, 8'h80};
      8'd6:    r_Data <= {7'h3C, 8'h05};
      8'd7:    r_Data <= {7'h68, 8'h7E};
      default: r_Data <= '0;
    endcase
  end

  assign o_Data = r_Data;

endmodule

// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - walks the config ROM and issues each entry as a single-byte I2C write
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES   = 8,
  parameter int MAX_RETRY     = 3,
  parameter int GAP_CYCLES    = 100,
  parameter int START_TIMEOUT = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Fail,
  output logic [7:0] o_Index,
  output logic       o_Mst_Enable,
  output logic [6:0] o_Mst_Slave_Addr,
  output logic [7:0] o_Mst_Wr_Byte,
  output logic       o_Mst_Wr_Start,
  output logic       o_Mst_Rd_Start,
  input  logic       i_Mst_Busy,
  input  logic       i_Mst_Error
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [7:0]       LAST_IDX = 8'(NUM_ENTRIES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  state_t             r_State;
  logic [7:0]         r_Index;
  logic [RTY_W-1:0]   r_Retry;
  logic [GAP_W-1:0]   r_Gap;
  logic [TMO_W-1:0]   r_Tmo;
  logic               r_Refetch;
  logic               r_Busy;
  logic               r_Done;
  logic               r_Fail;
  logic               r_Wr_Start;
  logic [6:0]         r_Slave_Addr;
  logic [7:0]         r_Wr_Byte;

  logic [ENTRY_W-1:0] w_Rom_Data;
  logic               w_Attempt_Ok;
  logic               w_Attempt_Bad;

  i2c_config_rom u_rom (
    .i_Clk  (i_Clk),
    .i_Addr (r_Index),
    .o_Data (w_Rom_Data)
  );

  // A timeout in WAIT_HI and a NACK at the busy fall are the same failed attempt.
  assign w_Attempt_Ok  = (r_State == S_WAIT_LO) && !i_Mst_Busy && !i_Mst_Error;
  assign w_Attempt_Bad = ((r_State == S_WAIT_LO) && !i_Mst_Busy && i_Mst_Error) ||
                         ((r_State == S_WAIT_HI) && !i_Mst_Busy && (r_Tmo == TMO_LAST));

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State      <= S_IDLE;
      r_Index      <= '0;
      r_Retry      <= '0;
      r_Gap        <= '0;
      r_Tmo        <= '0;
      r_Refetch    <= 1'b0;
      r_Busy       <= 1'b0;
      r_Done       <= 1'b0;
      r_Fail       <= 1'b0;
      r_Wr_Start   <= 1'b0;
      r_Slave_Addr <= '0;
      r_Wr_Byte    <= '0;
    end else begin
      r_Wr_Start <= 1'b0;
      case (r_State)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_Start) begin
            r_Index <= '0;
            r_Retry <= '0;
            r_Done  <= 1'b0;
            r_Fail  <= 1'b0;
            r_Busy  <= 1'b1;
            r_State <= S_FETCH;
          end
        end
        S_FETCH: r_State <= S_LOAD;
        S_LOAD: begin
          r_Slave_Addr <= w_Rom_Data[ADDR_MSB:ADDR_LSB];
          r_Wr_Byte    <= w_Rom_Data[DATA_MSB:DATA_LSB];
          r_State      <= S_ISSUE;
        end
        S_ISSUE: begin
          r_Wr_Start <= 1'b1;
          r_Tmo      <= '0;
          r_State    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (i_Mst_Busy) r_State <= S_WAIT_LO;
          else            r_Tmo   <= r_Tmo + TMO_W'(1);
        end
        S_WAIT_LO: ;
        S_GAP: begin
          if (r_Gap == '0) r_State <= r_Refetch ? S_FETCH : S_ISSUE;
          else             r_Gap   <= r_Gap - GAP_W'(1);
        end
        default: r_State <= S_IDLE;
      endcase

      if (w_Attempt_Ok) begin
        r_Retry <= '0;
        if (r_Index == LAST_IDX) begin
          r_Busy  <= 1'b0;
          r_Done  <= 1'b1;
          r_State <= S_DONE;
        end else begin
          r_Index   <= r_Index + 8'd1;
          r_Refetch <= 1'b1;
          r_Gap     <= GAP_LOAD;
          r_State   <= S_GAP;
        end
      end else if (w_Attempt_Bad) begin
        // Retry never exceeds RTY_MAX, so inequality means budget remains.
        if (r_Retry != RTY_MAX) begin
          r_Retry   <= r_Retry + RTY_W'(1);
          r_Refetch <= 1'b0;
          r_Gap     <= GAP_LOAD;
          r_State   <= S_GAP;
        end else begin
          r_Busy  <= 1'b0;
          r_Fail  <= 1'b1;
          r_State <= S_FAIL;
        end
      end
    end
  end

  assign o_Busy           = r_Busy;
  assign o_Done           = r_Done;
  assign o_Fail           = r_Fail;
  assign o_Index          = r_Index;
  assign o_Mst_Enable     = ~i_Rst;
  assign o_Mst_Slave_Addr = r_Slave_Addr;
  assign o_Mst_Wr_Byte    = r_Wr_Byte;
  assign o_Mst_Wr_Start   = r_Wr_Start;
  assign o_Mst_Rd_Start   = 1'b0;

endmodule
